// File: rtl/char_buffer_start.sv
// 16x16 start-screen character buffer: 1-cycle registered read port plus a byte-stream writer with
// newline/clear control codes. Define CHAR_BUF_START_MSG_EN to preload "PRESS START" after reset.
module char_buffer_start #(
    parameter logic [7:0] CLEAR_CHAR = 8'h20,
    parameter logic [7:0] NL_CHAR    = 8'h0A,
    parameter logic [7:0] FF_CHAR    = 8'h0C
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_xy,
    output logic [7:0] char_code,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    input  logic       clr_req,
    output logic       busy,
    output logic [7:0] cursor
);

    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
`ifdef CHAR_BUF_START_MSG_EN
    localparam logic [1:0] S_LOAD  = 2'd3;
    localparam logic [7:0] MSG_LAST = 8'd10;

    function automatic logic [7:0] msg_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    msg_byte = 8'h50;
            4'd1:    msg_byte = 8'h52;
            4'd2:    msg_byte = 8'h45;
            4'd3:    msg_byte = 8'h53;
            4'd4:    msg_byte = 8'h53;
            4'd5:    msg_byte = 8'h20;
            4'd6:    msg_byte = 8'h53;
            4'd7:    msg_byte = 8'h54;
            4'd8:    msg_byte = 8'h41;
            4'd9:    msg_byte = 8'h52;
            4'd10:   msg_byte = 8'h54;
            default: msg_byte = CLEAR_CHAR;
        endcase
    endfunction

    logic       r_load_pend;
`endif

    logic [7:0] r_mem [0:255];
    logic [1:0] r_state;
    logic [7:0] r_clr_addr;
    logic [7:0] r_cursor;
    logic [7:0] r_char_code;
    logic       r_clr_pend;

    logic       w_clr_any;
    logic       w_xfer;
    logic       w_is_ff;
    logic       w_is_nl;
    logic       w_data_wr;
    logic       w_we;
    logic [7:0] w_waddr;
    logic [7:0] w_wdata;

    // A clear request (live or latched during HOLD) wins over a pending byte, which stays unconsumed.
    assign w_clr_any = clr_req | r_clr_pend;
    assign w_xfer    = (r_state == S_IDLE) && wr_valid && !w_clr_any;
    assign w_is_ff   = (wr_data == FF_CHAR);
    assign w_is_nl   = (wr_data == NL_CHAR);
    assign w_data_wr = w_xfer && !w_is_ff && !w_is_nl;

    assign wr_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE) && (r_state != S_HOLD);
    assign cursor    = r_cursor;
    assign char_code = r_char_code;

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_cursor;
        w_wdata = wr_data;
        case (r_state)
            S_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_clr_addr;
                w_wdata = CLEAR_CHAR;
            end
`ifdef CHAR_BUF_START_MSG_EN
            S_LOAD: begin
                w_we    = 1'b1;
                w_waddr = r_clr_addr;
                w_wdata = msg_byte(r_clr_addr[3:0]);
            end
`endif
            S_IDLE:  w_we = w_data_wr;
            default: w_we = 1'b0;
        endcase
        if (rst) w_we = 1'b0;
    end

    // NOTE: the array has no reset; its contents are defined by the CLEAR sweep instead.
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    // NOTE: non-blocking read of the array gives the old data on a same-cycle same-address write.
    always_ff @(posedge clk) begin
        if (rst) r_char_code <= 8'h00;
        else     r_char_code <= r_mem[char_xy];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= 8'h00;
            r_cursor   <= 8'h00;
            r_clr_pend <= 1'b0;
`ifdef CHAR_BUF_START_MSG_EN
            r_load_pend <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_clr_addr <= r_clr_addr + 8'd1;
                    if (clr_req) begin
                        r_clr_addr <= 8'h00;
                    end else if (r_clr_addr == 8'hFF) begin
                        r_cursor <= 8'h00;
`ifdef CHAR_BUF_START_MSG_EN
                        r_state  <= r_load_pend ? S_LOAD : S_IDLE;
`else
                        r_state  <= S_IDLE;
`endif
                    end
                end
`ifdef CHAR_BUF_START_MSG_EN
                S_LOAD: begin
                    r_clr_addr <= r_clr_addr + 8'd1;
                    if (r_clr_addr == MSG_LAST) begin
                        r_state     <= S_IDLE;
                        r_cursor    <= 8'h10;
                        r_clr_addr  <= 8'h00;
                        r_load_pend <= 1'b0;
                    end
                end
`endif
                S_IDLE: begin
                    r_clr_pend <= 1'b0;
                    if (w_clr_any || (w_xfer && w_is_ff)) begin
                        r_state    <= S_CLEAR;
                        r_clr_addr <= 8'h00;
                    end else if (w_xfer && w_is_nl) begin
                        r_cursor <= {r_cursor[7:4] + 4'd1, 4'h0};
                    end else if (w_data_wr) begin
                        r_cursor <= r_cursor + 8'd1;
                        if (r_cursor == 8'hFF) r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    r_state <= S_IDLE;
                    if (clr_req) r_clr_pend <= 1'b1;
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_char_buffer_start.sv
// Self-checking bench for char_buffer_start: table-driven stream vectors, a read scoreboard queue,
// and hand-written sequences for reset, clear restart, same-address read/write and cursor wrap.
module tb_char_buffer_start;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] char_xy;
    logic [7:0] char_code;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       clr_req;
    logic       busy;
    logic [7:0] cursor;

    char_buffer_start dut (
        .clk       (clk),
        .rst       (rst),
        .char_xy   (char_xy),
        .char_code (char_code),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .clr_req   (clr_req),
        .busy      (busy),
        .cursor    (cursor)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_cursor;
    } stream_vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          hs    = 0;
    logic [7:0]  m [0:255];
    logic [7:0]  mc;
    logic [7:0]  exp_q [$];

    always @(posedge clk) begin
        if (wr_valid && wr_ready) hs <= hs + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model of one accepted non-control byte or newline.
    task automatic model_byte(input logic [7:0] b);
        if (b == 8'h0A) begin
            mc = {mc[7:4] + 4'd1, 4'h0};
        end else begin
            m[mc] = b;
            mc    = mc + 8'd1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        wr_valid = 1'b1;
        wr_data  = b;
        while (!wr_ready && n < 1000) begin
            step();
            n++;
        end
        if (n >= 1000) check("handshake_timeout", wr_ready, 1);
        step();
        wr_valid = 1'b0;
        model_byte(b);
    endtask

    // Streams addresses back-to-back; each expected code is popped one cycle after its address.
    task automatic sweep(input string tag);
        for (int i = 0; i < 256; i++) begin
            char_xy = i[7:0];
            exp_q.push_back(m[i]);
            step();
            check($sformatf("%s_rd[%02h]", tag, i), char_code, exp_q.pop_front());
        end
    endtask

    task automatic wait_idle(input string tag, input int exp_cycles);
        int n = 0;
        while (busy && n < 400) begin
            step();
            n++;
        end
        check({tag, "_busy_cycles"}, n, exp_cycles);
        check({tag, "_wr_ready"}, wr_ready, 1);
    endtask

    initial begin
        stream_vec_t tbl [4];
        logic [7:0]  msg [0:10];
        int          hs0;

        tbl[0] = '{8'h41, 8'h01};
        tbl[1] = '{8'h42, 8'h02};
        tbl[2] = '{8'h0A, 8'h10};
        tbl[3] = '{8'h43, 8'h11};
        msg = '{8'h50, 8'h52, 8'h45, 8'h53, 8'h53, 8'h20, 8'h53, 8'h54, 8'h41, 8'h52, 8'h54};

        rst = 1'b1; char_xy = 8'h00; wr_valid = 1'b0; wr_data = 8'h00; clr_req = 1'b0;
        repeat (3) step();
        check("rst_char_code", char_code, 8'h00);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_busy", busy, 1);
        check("rst_cursor", cursor, 8'h00);

        for (int i = 0; i < 256; i++) m[i] = 8'h20;
        rst = 1'b0;
`ifdef CHAR_BUF_START_MSG_EN
        for (int i = 0; i < 11; i++) m[i] = msg[i];
        mc = 8'h10;
        wait_idle("reset", 267);
`else
        mc = 8'h00;
        wait_idle("reset", 256);
`endif
        check("reset_cursor", cursor, mc);
        sweep("post_reset");

        // FF clear, restarted by clr_req when clr_addr has reached 100.
        send_byte(8'h51);
        wr_valid = 1'b1; wr_data = 8'h0C;
        step();
        wr_valid = 1'b0;
        check("ff_busy", busy, 1);
        repeat (100) step();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        wait_idle("restart", 256);
        for (int i = 0; i < 256; i++) m[i] = 8'h20;
        mc = 8'h00;
        check("clear_cursor", cursor, 8'h00);
        sweep("post_clear");

        // Same-address read and write: old data first, new data one cycle later.
        for (int i = 0; i < 5; i++) send_byte(8'h30 + i[7:0]);
        check("pre_same_cursor", cursor, 8'h05);
        char_xy = 8'h05;
        exp_q.push_back(m[5]);
        wr_valid = 1'b1; wr_data = 8'h5A;
        check("same_wr_ready", wr_ready, 1);
        step();
        wr_valid = 1'b0;
        model_byte(8'h5A);
        check("same_old", char_code, exp_q.pop_front());
        exp_q.push_back(m[5]);
        step();
        check("same_new", char_code, exp_q.pop_front());

        // Fill up to cell FE, then 'X' at FF wraps the cursor and opens a one-cycle HOLD.
        for (int i = 6; i < 255; i++) send_byte(8'h61 + 8'(i % 26));
        check("pre_wrap_cursor", cursor, 8'hFF);
        wr_valid = 1'b1; wr_data = 8'h58;
        step();
        wr_valid = 1'b0;
        model_byte(8'h58);
        check("wrap_cursor", cursor, 8'h00);
        check("hold_wr_ready", wr_ready, 0);
        step();
        check("post_hold_wr_ready", wr_ready, 1);

        // Back-to-back stream "AB", NL, "C" from cell 0.
        hs0 = hs;
        for (int k = 0; k < 4; k++) begin
            wr_valid = 1'b1;
            wr_data  = tbl[k].data;
            step();
            model_byte(tbl[k].data);
            check($sformatf("stream_cursor[%0d]", k), cursor, tbl[k].exp_cursor);
        end
        wr_valid = 1'b0;
        check("stream_handshakes", hs - hs0, 4);
        sweep("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/char_buffer_start.md
Name: char_buffer_start

Overview:
- 16x16 character buffer that holds the text shown in the start-screen text box.
- Sits directly upstream of the text-box drawing stage and the font ROM. The drawing stage drives char_xy (row in [7:4], column in [3:0]); this block returns the 8-bit character code one cycle later, and that code feeds the font ROM address.
- Text arrives as a byte stream over a valid/ready handshake and is placed at an internal cursor. Control bytes handle newline and clear.

Parameters:
- CLEAR_CHAR, 8'h20, code written to every cell during a clear.
- NL_CHAR, 8'h0A, byte that moves the cursor to column 0 of the next row; never stored.
- FF_CHAR, 8'h0C, byte that triggers a full clear and cursor home; never stored.

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset
- char_xy  in  8  read address: row [7:4], column [3:0]
- char_code  out  8  registered character code at the char_xy sampled on the previous edge
- wr_valid  in  1  stream byte valid
- wr_data  in  8  stream byte (ASCII)
- wr_ready  out  1  block can accept a byte this cycle
- clr_req  in  1  single-cycle request to clear the buffer
- busy  out  1  high while a clear is in progress
- cursor  out  8  current write position: row [7:4], column [3:0]

Behaviour:
- Reset: rst is synchronous and active-high; the clock is clk.
  - Outputs after reset: char_code=0, wr_ready=0, busy=1, cursor=0.
  - The FSM enters CLEAR. Memory contents are undefined until the clear completes.
- Storage: 256 x 8 array.
  - Read port: char_code <= mem[char_xy] on every edge, independent of FSM state. Latency is exactly 1 cycle.
  - Write port: independent of the read port.
  - Same-address read and write in one cycle: the read returns the old data.
- FSM states: CLEAR, IDLE, HOLD.
- CLEAR:
  - Internal counter clr_addr runs 0..255 and writes CLEAR_CHAR to mem[clr_addr] each cycle.
  - busy=1, wr_ready=0.
  - After clr_addr=255 is written: cursor=0, go to IDLE. A full clear takes exactly 256 cycles.
- IDLE:
  - wr_ready=1, busy=0.
  - clr_req=1 goes to CLEAR with clr_addr=0. clr_req has priority over wr_valid in the same cycle, and that byte is not consumed.
  - A transfer occurs when wr_valid and wr_ready are both high:
    - wr_data==FF_CHAR: go to CLEAR.
    - wr_data==NL_CHAR: cursor <= {cursor[7:4]+1, 4'h0}. Row 15 wraps to row 0.
    - Any other byte: mem[cursor] <= wr_data, then cursor <= cursor+1 (8-bit wrap). Column 15 carries into the next row; cell 255 wraps to 0.
  - Accepted data bytes can arrive back-to-back, one per cycle.
- HOLD:
  - Entered from IDLE when the last accepted data byte was written at cell 255.
  - wr_ready=0 for exactly one cycle, then IDLE. This gives the downstream stage a one-cycle boundary marker.
  - clr_req in HOLD is latched and acted on in the following IDLE cycle.
- clr_req while in CLEAR: the clear restarts at clr_addr=0.
- rst mid-clear or mid-stream: immediate return to the reset state; any unaccepted byte is dropped.

Optional Feature:
- Macro: CHAR_BUF_START_MSG_EN.
- Defined:
  - After the post-reset CLEAR, a LOAD state writes the fixed 11-byte string "PRESS START" to cells 8'h00..8'h0A, one per cycle.
  - Then cursor=8'h10 and the FSM goes to IDLE.
  - busy and wr_ready=0 are held through LOAD.
  - Total time from reset to IDLE: 267 cycles.
  - A FF_CHAR or clr_req clear does not reload the message.
- Undefined: LOAD is not present; reset goes CLEAR then IDLE with cursor=0.

Test Plan:
- Reset, then hold wr_valid=0 -> busy=1 for 256 cycles, then wr_ready=1. Sweeping char_xy 0..255 returns 8'h20 for every cell, each code appearing one cycle after its address.
- Stream "AB", NL, "C" back-to-back -> mem[00]=41, mem[01]=42, mem[10]=43, cursor=8'h11; exactly 4 handshakes in 4 cycles.
- Set cursor to 8'hFF via 255 writes, then send "X" -> mem[FF]=58, cursor=0, wr_ready=0 for one cycle; the next byte lands at cell 0.
- Assert wr_valid with wr_data=0x0C, then assert clr_req while that clear is at clr_addr=100 -> busy stays high for 256 cycles counted from the restart, then all cells read 20 and cursor=0.
- Drive char_xy=8'h05 while writing 8'h5A to cell 05 in the same cycle -> char_code shows the old value next cycle, and 5A the cycle after that.
- With CHAR_BUF_START_MSG_EN defined, reset -> cells 00..0A read "PRESS START" (50 52 45 53 53 20 53 54 41 52 54), busy falls after 267 cycles, cursor=8'h10.
